// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/arith-shift/load/clear with serial out,
// shift counter and a one-cycle frame pulse every WIDTH shifts.
module univ_shift_reg #(
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out,
   output logic             sout,
   output logic [CW-1:0]    cnt,
   output logic             frame_done
);

   typedef enum logic [2:0] {
      M_HOLD  = 3'd0,
      M_SHL   = 3'd1,
      M_SHR   = 3'd2,
      M_ROL   = 3'd3,
      M_ROR   = 3'd4,
      M_ASR   = 3'd5,
      M_LOAD  = 3'd6,
      M_CLEAR = 3'd7
   } mode_e;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             sout_q, sout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fd_q, fd_d;
   logic             shift_op;

   always_comb begin
      out_d    = out_q;
      sout_d   = sout_q;
      cnt_d    = cnt_q;
      fd_d     = 1'b0;
      shift_op = 1'b0;
      if (en) begin
         case (mode_e'(mode))
            M_SHL: begin
               out_d    = {out_q[WIDTH-2:0], sin};
               sout_d   = out_q[WIDTH-1];
               shift_op = 1'b1;
            end
            M_SHR: begin
               out_d    = {sin, out_q[WIDTH-1:1]};
               sout_d   = out_q[0];
               shift_op = 1'b1;
            end
            M_ROL: begin
               out_d    = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
               sout_d   = out_q[WIDTH-1];
               shift_op = 1'b1;
            end
            M_ROR: begin
               out_d    = {out_q[0], out_q[WIDTH-1:1]};
               sout_d   = out_q[0];
               shift_op = 1'b1;
            end
            M_ASR: begin
               out_d    = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
               sout_d   = out_q[0];
               shift_op = 1'b1;
            end
            M_LOAD: begin
               out_d = load_data;
               cnt_d = '0;
            end
            M_CLEAR: begin
               out_d  = '0;
               sout_d = 1'b0;
               cnt_d  = '0;
            end
            default: ;
         endcase
         // Frame boundary: the WIDTH-th shift wraps the counter and fires the pulse.
         if (shift_op) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               fd_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         sout_q <= 1'b0;
         cnt_q  <= '0;
         fd_q   <= 1'b0;
      end else begin
         out_q  <= out_d;
         sout_q <= sout_d;
         cnt_q  <= cnt_d;
         fd_q   <= fd_d;
      end
   end

   assign out        = out_q;
   assign sout       = sout_q;
   assign cnt        = cnt_q;
   assign frame_done = fd_q;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the register width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have parameter CW, default $clog2(WIDTH), giving the shift-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: operation enable; 0 holds all state.
REQ-006 SHALL have port mode, input, 3 bits: operation select per REQ-010.
REQ-007 SHALL have ports sin (input, 1 bit, serial data in) and load_data (input, WIDTH bits, parallel load value).
REQ-008 SHALL have port out, output, WIDTH bits, registered: current register contents.
REQ-009 SHALL have ports sout (output, 1 bit, registered, last bit shifted or rotated out), cnt (output, CW bits, registered, shifts since last load/clear) and frame_done (output, 1 bit, registered, one-cycle pulse).

Function
REQ-010 SHALL decode mode as follows (all only when en=1):
- 0 HOLD
- 1 SHL: out <= {out[WIDTH-2:0], sin}
- 2 SHR: out <= {sin, out[WIDTH-1:1]}
- 3 ROL: out <= {out[WIDTH-2:0], out[WIDTH-1]}
- 4 ROR: out <= {out[0], out[WIDTH-1:1]}
- 5 ASR: out <= {out[WIDTH-1], out[WIDTH-1:1]}
- 6 LOAD: out <= load_data
- 7 CLEAR: out <= 0
REQ-011 SHALL take effect one clock edge after the cycle in which mode/en are sampled, with no additional latency.
REQ-012 SHALL update sout on each shift/rotate op: SHL and ROL give the old out[WIDTH-1]; SHR, ROR and ASR give the old out[0].
REQ-013 SHALL hold sout under HOLD and LOAD, and clear it to 0 under CLEAR.
REQ-014 SHALL treat modes 1-5 as shift ops, each incrementing cnt by 1.
REQ-015 SHALL, on a shift op with cnt == WIDTH-1, wrap cnt to 0 and assert frame_done for exactly the following cycle.
REQ-016 SHALL, on LOAD or CLEAR, set cnt to 0 and frame_done to 0.
REQ-017 SHALL deassert frame_done in every cycle not covered by REQ-015; back-to-back frames produce one pulse per WIDTH shifts.
REQ-018 SHALL, with en=0, hold out, sout and cnt regardless of mode, and drive frame_done to 0.
REQ-019 SHALL avoid combinational paths from inputs to outputs; all outputs come directly from flops.

Reset
REQ-020 SHALL, while rst=1, immediately and asynchronously force out=0, sout=0, cnt=0 and frame_done=0, independent of clk.
REQ-021 SHALL take precedence of rst over en and mode; rst asserted mid-frame discards the partial frame, and counting restarts from 0 after release.
REQ-022 SHALL perform the first operation on the first rising clk edge after rst deasserts, with no extra idle cycle.

Verification (WIDTH=8)
REQ-023 SHALL cover reset: LOAD 0xFF, 3x SHL, then assert rst between edges -> out=0x00, sout=0, cnt=0, frame_done=0 before the next edge.
REQ-024 SHALL cover shift-left: LOAD 0xA5, then SHL with sin=1 -> out=0x4B, sout=1, cnt=1.
REQ-025 SHALL cover rotate: LOAD 0x81, ROR -> out=0xC0, sout=1; then ROL -> out=0x81, sout=1, cnt=2.
REQ-026 SHALL cover arithmetic shift: LOAD 0x80, 3x ASR -> out=0xF0, sout=0.
REQ-027 SHALL cover frame: CLEAR, then 8x SHR with sin sequence 1,0,1,1,0,0,1,0 -> out=0x4D, cnt=0, frame_done high only in the cycle after the 8th shift.
REQ-028 SHALL cover enable gating: en=0 with mode=LOAD and load_data=0x3C for 4 cycles -> out, sout and cnt unchanged, frame_done=0.
